rgb_motion_detect: RTL

- Downstream consumer of the Bayer-to-RGB stage. Takes 8-bit R/G/B per displayed pixel in the VGA_CLK domain.
- Converts each pixel to luma and accumulates luma over a programmable region of interest (ROI).
- At each frame boundary, compares the ROI sum with the previous frame's sum to flag motion, and drives an alert state machine for the security controller.

---
 rtl/rgb_motion_detect_pkg.sv | 19 +
 rtl/rgb_motion_detect_if.sv | 13 +
 rtl/rgb_motion_detect_rgb_to_luma.sv | 29 ++
 rtl/rgb_motion_detect.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rgb_motion_detect_pkg.sv
// rtl/rgb_motion_detect_pkg.sv - shared D8M/VGA constants, luma weights and alert FSM encoding
package rgb_motion_detect_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 11;

  // Weights sum to 256 so a grey pixel maps to exactly its own level.
  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    ALERT  = 2'd2
  } alertState_t;

endpackage

// File: rtl/rgb_motion_detect_if.sv
// rtl/rgb_motion_detect_if.sv - pixel stream from the Bayer-to-RGB stage
interface rgb_motion_detect_if;

  logic       READ_Request;
  logic       VGA_VS;
  logic [7:0] iRed;
  logic [7:0] iGreen;
  logic [7:0] iBlue;

  modport master (output READ_Request, VGA_VS, iRed, iGreen, iBlue);
  modport slave  (input  READ_Request, VGA_VS, iRed, iGreen, iBlue);

endinterface

// File: rtl/rgb_motion_detect_rgb_to_luma.sv
// rtl/rgb_motion_detect_rgb_to_luma.sv - registered 8-bit luma from 8-bit R/G/B
module rgb_to_luma
  import rgb_motion_detect_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       iValid,
  input  logic [7:0] iRed,
  input  logic [7:0] iGreen,
  input  logic [7:0] iBlue,
  output logic [7:0] oLuma
);

  logic [15:0] weighted;

  // Max value is 256*255, so 16 bits never overflow.
  assign weighted = 16'(LUMA_R) * {8'd0, iRed}
                  + 16'(LUMA_G) * {8'd0, iGreen}
                  + 16'(LUMA_B) * {8'd0, iBlue};

  always_ff @(posedge clk) begin
    if (rst) begin
      oLuma <= '0;
    end else if (iValid) begin
      oLuma <= 8'(weighted >> 8);
    end
  end

endmodule

// File: rtl/rgb_motion_detect.sv
// rtl/rgb_motion_detect.sv - ROI luma accumulator, frame-to-frame motion test and alert FSM
module rgb_motion_detect #(
  parameter int DATA_DELAY    = 2,
  parameter int H_ACTIVE      = rgb_motion_detect_pkg::H_ACTIVE,
  parameter int V_ACTIVE      = rgb_motion_detect_pkg::V_ACTIVE,
  parameter int WARMUP_FRAMES = 4,
  parameter int MOTION_FRAMES = 2,
  parameter int HOLD_FRAMES   = 30,
  parameter int SUM_W         = 27
) (
  input  logic                 VGA_CLK,
  input  logic                 RST,
  rgb_motion_detect_if.slave   pix,
  input  logic [10:0]          iRoiX0,
  input  logic [10:0]          iRoiX1,
  input  logic [10:0]          iRoiY0,
  input  logic [10:0]          iRoiY1,
  input  logic [SUM_W-1:0]     iThresh,
  output logic [SUM_W-1:0]     oLumaSum,
  output logic                 oFrameDone,
  output logic                 oMotion,
  output logic                 oAlert,
  output logic [15:0]          oEventCnt
);

  import rgb_motion_detect_pkg::*;

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - 1);

  logic [DATA_DELAY-1:0] reqPipe;
  logic                  reqD, reqDLast, vsQ, vsQQ, frameEnd;
  logic [10:0]           posX, posY, pixX, pixY;
  logic                  pixValid, inRoi;
  logic [7:0]            luma;
  logic [SUM_W-1:0]      acc, prevSum, diff;
  logic                  prevValid, motionNow;
  alertState_t           state, stateNext;
  logic [15:0]           frameCnt, frameCntNext, mcnt, mcntNext, hold, holdNext, eventNext;

  assign reqD     = reqPipe[DATA_DELAY-1];
  assign frameEnd = vsQQ & ~vsQ;

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      reqPipe  <= '0;
      reqDLast <= 1'b0;
      vsQ      <= 1'b0;
      vsQQ     <= 1'b0;
      posX     <= '0;
      posY     <= '0;
    end else begin
      reqPipe  <= DATA_DELAY'({reqPipe, pix.READ_Request});
      reqDLast <= reqD;
      vsQ      <= pix.VGA_VS;
      vsQQ     <= vsQ;
      if (!pix.VGA_VS) begin
        posX <= '0;
        posY <= '0;
      end else if (reqD) begin
        if (posX != X_MAX) posX <= posX + 11'd1;
      end else if (reqDLast) begin
        posX <= '0;
        if (posY != Y_MAX) posY <= posY + 11'd1;
      end
    end
  end

  rgb_to_luma u_luma (
    .clk    (VGA_CLK),
    .rst    (RST),
    .iValid (reqD),
    .iRed   (pix.iRed),
    .iGreen (pix.iGreen),
    .iBlue  (pix.iBlue),
    .oLuma  (luma)
  );

  // Coordinates follow the luma register so both describe the same pixel.
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      pixValid <= 1'b0;
      pixX     <= '0;
      pixY     <= '0;
    end else begin
      pixValid <= reqD;
      pixX     <= posX;
      pixY     <= posY;
    end
  end

  assign inRoi = (pixX >= iRoiX0) && (pixX <= iRoiX1) && (pixY >= iRoiY0) && (pixY <= iRoiY1);
  assign diff  = (acc >= prevSum) ? (acc - prevSum) : (prevSum - acc);
  assign motionNow = prevValid && (diff > iThresh) && (state != WARMUP);

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      acc        <= '0;
      prevSum    <= '0;
      prevValid  <= 1'b0;
      oLumaSum   <= '0;
      oFrameDone <= 1'b0;
      oMotion    <= 1'b0;
    end else begin
      oFrameDone <= frameEnd;
      if (frameEnd) begin
        oLumaSum  <= acc;
        acc       <= '0;
        prevSum   <= acc;
        prevValid <= 1'b1;
        oMotion   <= motionNow;
      end else if (pixValid && inRoi) begin
        acc <= acc + SUM_W'(luma);
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      state     <= WARMUP;
      frameCnt  <= '0;
      mcnt      <= '0;
      hold      <= '0;
      oEventCnt <= '0;
      oAlert    <= 1'b0;
    end else begin
      state     <= stateNext;
      frameCnt  <= frameCntNext;
      mcnt      <= mcntNext;
      hold      <= holdNext;
      oEventCnt <= eventNext;
      oAlert    <= (stateNext == ALERT);
    end
  end

  always_comb begin
    stateNext    = state;
    frameCntNext = frameCnt;
    mcntNext     = mcnt;
    holdNext     = hold;
    eventNext    = oEventCnt;
    if (frameEnd) begin
      unique case (state)
        WARMUP: begin
          frameCntNext = frameCnt + 16'd1;
          if (frameCnt + 16'd1 == 16'(WARMUP_FRAMES)) stateNext = IDLE;
        end
        IDLE: begin
          if (motionNow) begin
            if (mcnt + 16'd1 == 16'(MOTION_FRAMES)) begin
              stateNext = ALERT;
              mcntNext  = '0;
              holdNext  = 16'(HOLD_FRAMES);
              if (oEventCnt != 16'hFFFF) eventNext = oEventCnt + 16'd1;
            end else begin
              mcntNext = mcnt + 16'd1;
            end
          end else begin
            mcntNext = '0;
          end
        end
        ALERT: begin
          if (motionNow) begin
            holdNext = 16'(HOLD_FRAMES);
          end else if (hold <= 16'd1) begin
            stateNext = IDLE;
            holdNext  = '0;
            mcntNext  = '0;
          end else begin
            holdNext = hold - 16'd1;
          end
        end
        default: stateNext = WARMUP;
      endcase
    end
  end

endmodule
